// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and time field widths for the alarm controller
package alarm_pkg;

    localparam int SECS_W        = 6;
    localparam int MINS_W        = 6;
    localparam int HOURS_W       = 4;
    localparam int MINS_PER_HOUR = 60;
    localparam int HOURS_MAX     = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/alarm_time_add.sv
// rtl/alarm_time_add.sv - combinational 12-hour time plus N minutes (N<60) with AM/PM roll-over
module alarm_time_add
    import alarm_pkg::*;
(
    input  logic [MINS_W-1:0]  i_mins,
    input  logic [HOURS_W-1:0] i_hours,
    input  logic               i_am_pm,
    input  logic [MINS_W-1:0]  i_add_mins,
    output logic [MINS_W-1:0]  o_mins,
    output logic [HOURS_W-1:0] o_hours,
    output logic               o_am_pm
);

    logic [MINS_W:0] w_sum;
    logic [MINS_W:0] w_wrapped;
    logic            w_carry;

    assign w_sum     = {1'b0, i_mins} + {1'b0, i_add_mins};
    assign w_carry   = (w_sum >= (MINS_W+1)'(MINS_PER_HOUR));
    assign w_wrapped = w_sum - (MINS_W+1)'(MINS_PER_HOUR);

    // Minute wrap advances the hour; 11->12 flips AM/PM, 12->1 does not (matches datapath roll-over)
    always_comb begin
        o_mins  = w_sum[MINS_W-1:0];
        o_hours = i_hours;
        o_am_pm = i_am_pm;
        if (w_carry) begin
            o_mins = w_wrapped[MINS_W-1:0];
            if (i_hours == HOURS_W'(HOURS_MAX)) begin
                o_hours = HOURS_W'(1);
            end else begin
                o_hours = i_hours + HOURS_W'(1);
            end
            if (i_hours == HOURS_W'(HOURS_MAX - 1)) begin
                o_am_pm = ~i_am_pm;
            end
        end
    end

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// rtl/alarm_snooze_ctrl.sv - ring/snooze/stop sequencer driving the alarm registers of the clock datapath
module alarm_snooze_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MINS = 9,
    parameter int RING_SECS   = 60,
    parameter int MAX_SNOOZES = 3
) (
    input  logic               Clock_1Sec,
    input  logic               Reset,
    input  logic               AlarmMatch,
    input  logic [SECS_W-1:0]  Secs_C,
    input  logic [MINS_W-1:0]  Mins_C,
    input  logic [HOURS_W-1:0] Hours_C,
    input  logic               AM_PM,
    input  logic               UserLoadAlm,
    input  logic [MINS_W-1:0]  UserMins,
    input  logic [HOURS_W-1:0] UserHours,
    input  logic               UserAM_PM,
    input  logic               AlarmEnableIn,
    input  logic               SnoozeBtn,
    input  logic               StopBtn,
    output logic               LoadAlm,
    output logic [MINS_W-1:0]  AlarmMinsOut,
    output logic [HOURS_W-1:0] AlarmHoursOut,
    output logic               AlarmAM_PMOut,
    output logic               AlarmEnable,
    output logic               Buzzer,
    output logic               Snoozing,
    output logic [2:0]         SnoozeCnt
);

    localparam logic [MINS_W-1:0] SNZ_ADD   = MINS_W'(SNOOZE_MINS);
    localparam logic [5:0]        RING_LAST = 6'(RING_SECS - 1);
    localparam logic [2:0]        SNZ_MAX   = 3'(MAX_SNOOZES);

    alarm_state_t       r_state;
    logic               r_match_q;
    logic [5:0]         r_ring_cnt;
    logic [2:0]         r_snooze_cnt;
    logic               r_buzzer;
    logic               r_snoozing;
    logic [MINS_W-1:0]  r_user_mins;
    logic [HOURS_W-1:0] r_user_hours;
    logic               r_user_am_pm;
    logic               r_load_alm;
    logic [MINS_W-1:0]  r_alm_mins;
    logic [HOURS_W-1:0] r_alm_hours;
    logic               r_alm_am_pm;
    logic               r_pend;
    logic [MINS_W-1:0]  r_pend_mins;
    logic [HOURS_W-1:0] r_pend_hours;
    logic               r_pend_am_pm;

    logic               w_match_rise;
    logic               w_timeout;
    logic               w_snz_left;
    logic               w_active;
    logic               w_disable;
    logic               w_ring_snooze;
    logic               w_ring_stop;
    logic               w_snz_stop;
    logic               w_restore;
    logic               w_ring_start;
    logic               w_need_load;
    logic [MINS_W-1:0]  w_ld_mins;
    logic [HOURS_W-1:0] w_ld_hours;
    logic               w_ld_am_pm;
    logic [MINS_W-1:0]  w_snz_mins;
    logic [HOURS_W-1:0] w_snz_hours;
    logic               w_snz_am_pm;
    logic               w_unused;

    // Seconds do not influence the snooze target; only whole minutes are reloaded
    assign w_unused = ^Secs_C;

    assign AlarmEnable   = AlarmEnableIn;
    assign LoadAlm       = r_load_alm;
    assign AlarmMinsOut  = r_alm_mins;
    assign AlarmHoursOut = r_alm_hours;
    assign AlarmAM_PMOut = r_alm_am_pm;
    assign Buzzer        = r_buzzer;
    assign Snoozing      = r_snoozing;
    assign SnoozeCnt     = r_snooze_cnt;

    alarm_time_add u_snooze_add (
        .i_mins     (Mins_C),
        .i_hours    (Hours_C),
        .i_am_pm    (AM_PM),
        .i_add_mins (SNZ_ADD),
        .o_mins     (w_snz_mins),
        .o_hours    (w_snz_hours),
        .o_am_pm    (w_snz_am_pm)
    );

    // The datapath holds AlarmMatch for the whole minute, so only its rising edge is an event
    assign w_match_rise = AlarmMatch & ~r_match_q;
    assign w_timeout    = (r_ring_cnt == RING_LAST);
    assign w_snz_left   = (r_snooze_cnt < SNZ_MAX);

    // Event decode in priority order: user load, disable, stop, snooze, timeout, match
    always_comb begin
        w_active      = ~UserLoadAlm & AlarmEnableIn;
        w_disable     = ~UserLoadAlm & ~AlarmEnableIn & (r_state != ST_IDLE);
        w_ring_stop   = w_active & (r_state == ST_RINGING) &
                        (StopBtn | (w_timeout & ~w_snz_left));
        w_ring_snooze = w_active & (r_state == ST_RINGING) & ~StopBtn &
                        w_snz_left & (SnoozeBtn | w_timeout);
        w_snz_stop    = w_active & (r_state == ST_SNOOZE) & StopBtn;
        w_restore     = w_disable | w_ring_stop | w_snz_stop;
        w_ring_start  = w_active & w_match_rise &
                        ((r_state == ST_IDLE) | ((r_state == ST_SNOOZE) & ~StopBtn));
        w_need_load   = UserLoadAlm | w_restore | w_ring_snooze;
        w_ld_mins     = w_snz_mins;
        w_ld_hours    = w_snz_hours;
        w_ld_am_pm    = w_snz_am_pm;
        if (UserLoadAlm) begin
            w_ld_mins  = UserMins;
            w_ld_hours = UserHours;
            w_ld_am_pm = UserAM_PM;
        end else if (w_restore) begin
            w_ld_mins  = r_user_mins;
            w_ld_hours = r_user_hours;
            w_ld_am_pm = r_user_am_pm;
        end
    end

    // Main FSM: state, buzzer, snooze bookkeeping and the stored user alarm
    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            r_match_q    <= 1'b0;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_buzzer     <= 1'b0;
            r_snoozing   <= 1'b0;
            r_user_mins  <= '0;
            r_user_hours <= HOURS_W'(HOURS_MAX);
            r_user_am_pm <= 1'b0;
        end else begin
            r_match_q <= AlarmMatch;
            if (UserLoadAlm) begin
                r_user_mins  <= UserMins;
                r_user_hours <= UserHours;
                r_user_am_pm <= UserAM_PM;
            end
            if (UserLoadAlm | w_restore) begin
                r_state      <= ST_IDLE;
                r_buzzer     <= 1'b0;
                r_snoozing   <= 1'b0;
                r_snooze_cnt <= '0;
            end else if (w_ring_snooze) begin
                r_state      <= ST_SNOOZE;
                r_buzzer     <= 1'b0;
                r_snoozing   <= 1'b1;
                r_snooze_cnt <= r_snooze_cnt + 3'd1;
            end else if (w_ring_start) begin
                r_state    <= ST_RINGING;
                r_buzzer   <= 1'b1;
                r_snoozing <= 1'b0;
                r_ring_cnt <= '0;
            end else if (r_state == ST_RINGING) begin
                r_ring_cnt <= r_ring_cnt + 6'd1;
            end
        end
    end

    // Load sequencer: one-cycle strobes only; a load requested during a strobe is deferred one gap cycle
    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            r_load_alm   <= 1'b0;
            r_alm_mins   <= '0;
            r_alm_hours  <= HOURS_W'(HOURS_MAX);
            r_alm_am_pm  <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_mins  <= '0;
            r_pend_hours <= HOURS_W'(HOURS_MAX);
            r_pend_am_pm <= 1'b0;
        end else if (w_need_load) begin
            if (r_load_alm) begin
                r_load_alm   <= 1'b0;
                r_pend       <= 1'b1;
                r_pend_mins  <= w_ld_mins;
                r_pend_hours <= w_ld_hours;
                r_pend_am_pm <= w_ld_am_pm;
            end else begin
                r_load_alm  <= 1'b1;
                r_pend      <= 1'b0;
                r_alm_mins  <= w_ld_mins;
                r_alm_hours <= w_ld_hours;
                r_alm_am_pm <= w_ld_am_pm;
            end
        end else if (r_pend && !r_load_alm) begin
            r_load_alm  <= 1'b1;
            r_pend      <= 1'b0;
            r_alm_mins  <= r_pend_mins;
            r_alm_hours <= r_pend_hours;
            r_alm_am_pm <= r_pend_am_pm;
        end else begin
            r_load_alm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// tb/tb_alarm_snooze_ctrl.sv - directed self-checking bench for alarm_snooze_ctrl
module tb_alarm_snooze_ctrl;

    logic       Clock_1Sec = 1'b0;
    logic       Reset;
    logic       AlarmMatch;
    logic [5:0] Secs_C;
    logic [5:0] Mins_C;
    logic [3:0] Hours_C;
    logic       AM_PM;
    logic       UserLoadAlm;
    logic [5:0] UserMins;
    logic [3:0] UserHours;
    logic       UserAM_PM;
    logic       AlarmEnableIn;
    logic       SnoozeBtn;
    logic       StopBtn;
    logic       LoadAlm;
    logic [5:0] AlarmMinsOut;
    logic [3:0] AlarmHoursOut;
    logic       AlarmAM_PMOut;
    logic       AlarmEnable;
    logic       Buzzer;
    logic       Snoozing;
    logic [2:0] SnoozeCnt;

    int checks = 0;
    int errors = 0;

    alarm_snooze_ctrl #(.SNOOZE_MINS(9), .RING_SECS(60), .MAX_SNOOZES(3)) dut (
        .Clock_1Sec    (Clock_1Sec),
        .Reset         (Reset),
        .AlarmMatch    (AlarmMatch),
        .Secs_C        (Secs_C),
        .Mins_C        (Mins_C),
        .Hours_C       (Hours_C),
        .AM_PM         (AM_PM),
        .UserLoadAlm   (UserLoadAlm),
        .UserMins      (UserMins),
        .UserHours     (UserHours),
        .UserAM_PM     (UserAM_PM),
        .AlarmEnableIn (AlarmEnableIn),
        .SnoozeBtn     (SnoozeBtn),
        .StopBtn       (StopBtn),
        .LoadAlm       (LoadAlm),
        .AlarmMinsOut  (AlarmMinsOut),
        .AlarmHoursOut (AlarmHoursOut),
        .AlarmAM_PMOut (AlarmAM_PMOut),
        .AlarmEnable   (AlarmEnable),
        .Buzzer        (Buzzer),
        .Snoozing      (Snoozing),
        .SnoozeCnt     (SnoozeCnt)
    );

    always #5 Clock_1Sec = ~Clock_1Sec;

    task automatic tick();
        @(posedge Clock_1Sec);
        #1;
    endtask

    task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s, input logic ap);
        Hours_C = h; Mins_C = m; Secs_C = s; AM_PM = ap;
    endtask

    task automatic ring_start();
        AlarmMatch = 1'b1;
        tick();
        AlarmMatch = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %0b expected 0", Buzzer); end
        checks++; if (Snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %0b expected 0", Snoozing); end
        checks++; if (SnoozeCnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", SnoozeCnt); end
        checks++; if (LoadAlm !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b expected 0", LoadAlm); end
        checks++; if ({AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {4'd12, 6'd0, 1'b0}) begin errors++; $display("FAIL reset_alarm_out: got %0d:%0d/%0b expected 12:0/0", AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        Reset = 1'b1;
        AlarmEnableIn = 1'b1;
        #1;
        checks++; if (AlarmEnable !== 1'b1) begin errors++; $display("FAIL enable_follow_hi: got %0b expected 1", AlarmEnable); end
        tick();
    endtask

    task automatic test_user_load();
        UserHours = 4'd6; UserMins = 6'd30; UserAM_PM = 1'b0; UserLoadAlm = 1'b1;
        tick();
        UserLoadAlm = 1'b0;
        checks++; if (LoadAlm !== 1'b1) begin errors++; $display("FAIL user_load_strobe: got %0b expected 1", LoadAlm); end
        checks++; if ({AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {4'd6, 6'd30, 1'b0}) begin errors++; $display("FAIL user_load_data: got %0d:%0d/%0b expected 6:30/0", AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        tick();
        checks++; if (LoadAlm !== 1'b0) begin errors++; $display("FAIL user_load_width: got %0b expected 0", LoadAlm); end
        checks++; if (AlarmMinsOut !== 6'd30) begin errors++; $display("FAIL user_load_hold: got %0d expected 30", AlarmMinsOut); end
    endtask

    task automatic test_trigger_no_retrigger();
        int seen;
        set_time(4'd6, 6'd30, 6'd0, 1'b0);
        AlarmMatch = 1'b1;
        tick();
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("FAIL trig_buzzer: got %0b expected 1", Buzzer); end
        for (int i = 0; i < 4; i++) tick();
        StopBtn = 1'b1;
        tick();
        StopBtn = 1'b0;
        checks++; if ({Buzzer, LoadAlm, SnoozeCnt} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL trig_stop: got buz=%0b ld=%0b cnt=%0d expected 0 1 0", Buzzer, LoadAlm, SnoozeCnt); end
        checks++; if ({AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {4'd6, 6'd30, 1'b0}) begin errors++; $display("FAIL trig_stop_restore: got %0d:%0d/%0b expected 6:30/0", AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (Buzzer === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL no_retrigger: got %0d ringing cycles expected 0", seen); end
        AlarmMatch = 1'b0;
        tick();
    endtask

    task automatic test_snooze_wrap_pm();
        set_time(4'd11, 6'd55, 6'd10, 1'b1);
        ring_start();
        SnoozeBtn = 1'b1;
        tick();
        SnoozeBtn = 1'b0;
        checks++; if (LoadAlm !== 1'b1) begin errors++; $display("FAIL snz_pm_strobe: got %0b expected 1", LoadAlm); end
        checks++; if ({AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {4'd12, 6'd4, 1'b0}) begin errors++; $display("FAIL snz_pm_time: got %0d:%0d/%0b expected 12:4/0", AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        checks++; if ({Snoozing, Buzzer, SnoozeCnt} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL snz_pm_state: got snz=%0b buz=%0b cnt=%0d expected 1 0 1", Snoozing, Buzzer, SnoozeCnt); end
        tick();
        ring_start();
        checks++; if ({Buzzer, Snoozing, SnoozeCnt} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL snz_rering: got buz=%0b snz=%0b cnt=%0d expected 1 0 1", Buzzer, Snoozing, SnoozeCnt); end
        StopBtn = 1'b1;
        tick();
        StopBtn = 1'b0;
        checks++; if ({LoadAlm, AlarmMinsOut, SnoozeCnt} !== {1'b1, 6'd30, 3'd0}) begin errors++; $display("FAIL snz_pm_stop: got ld=%0b min=%0d cnt=%0d expected 1 30 0", LoadAlm, AlarmMinsOut, SnoozeCnt); end
        tick();
    endtask

    task automatic test_snooze_12_58();
        set_time(4'd12, 6'd58, 6'd0, 1'b1);
        ring_start();
        SnoozeBtn = 1'b1;
        tick();
        SnoozeBtn = 1'b0;
        checks++; if ({LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {1'b1, 4'd1, 6'd7, 1'b1}) begin errors++; $display("FAIL snz_12_58: got ld=%0b %0d:%0d/%0b expected 1 1:7/1", LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        StopBtn = 1'b1;
        tick();
        StopBtn = 1'b0;
        checks++; if ({LoadAlm, Snoozing, AlarmMinsOut} !== {1'b0, 1'b0, 6'd7}) begin errors++; $display("FAIL b2b_gap: got ld=%0b snz=%0b min=%0d expected 0 0 7", LoadAlm, Snoozing, AlarmMinsOut); end
        tick();
        checks++; if ({LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {1'b1, 4'd6, 6'd30, 1'b0}) begin errors++; $display("FAIL b2b_reload: got ld=%0b %0d:%0d/%0b expected 1 6:30/0", LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        tick();
    endtask

    task automatic test_auto_snooze();
        int n;
        set_time(4'd6, 6'd30, 6'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            ring_start();
            n = 0;
            while (Snoozing !== 1'b1 && n < 100) begin tick(); n++; end
            checks++; if (n !== 60) begin errors++; $display("FAIL auto_snz_%0d_cycles: got %0d expected 60", k, n); end
            checks++; if ({LoadAlm, AlarmMinsOut, SnoozeCnt} !== {1'b1, 6'd39, 3'(k)}) begin errors++; $display("FAIL auto_snz_%0d_load: got ld=%0b min=%0d cnt=%0d expected 1 39 %0d", k, LoadAlm, AlarmMinsOut, SnoozeCnt, k); end
            tick();
        end
        ring_start();
        SnoozeBtn = 1'b1;
        tick();
        SnoozeBtn = 1'b0;
        n = 1;
        checks++; if ({Buzzer, LoadAlm, SnoozeCnt} !== {1'b1, 1'b0, 3'd3}) begin errors++; $display("FAIL snz_limit_ignored: got buz=%0b ld=%0b cnt=%0d expected 1 0 3", Buzzer, LoadAlm, SnoozeCnt); end
        while (Buzzer !== 1'b0 && n < 100) begin tick(); n++; end
        checks++; if (n !== 60) begin errors++; $display("FAIL auto_stop_cycles: got %0d expected 60", n); end
        checks++; if ({Snoozing, SnoozeCnt, LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {1'b0, 3'd0, 1'b1, 4'd6, 6'd30, 1'b0}) begin errors++; $display("FAIL auto_stop_restore: got snz=%0b cnt=%0d ld=%0b %0d:%0d/%0b expected 0 0 1 6:30/0", Snoozing, SnoozeCnt, LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        tick();
    endtask

    task automatic test_stop_wins();
        ring_start();
        SnoozeBtn = 1'b1; StopBtn = 1'b1;
        tick();
        SnoozeBtn = 1'b0; StopBtn = 1'b0;
        checks++; if ({Buzzer, Snoozing, SnoozeCnt, LoadAlm, AlarmMinsOut} !== {1'b0, 1'b0, 3'd0, 1'b1, 6'd30}) begin errors++; $display("FAIL stop_wins: got buz=%0b snz=%0b cnt=%0d ld=%0b min=%0d expected 0 0 0 1 30", Buzzer, Snoozing, SnoozeCnt, LoadAlm, AlarmMinsOut); end
        tick();
    endtask

    task automatic test_disable_in_snooze();
        ring_start();
        SnoozeBtn = 1'b1;
        tick();
        SnoozeBtn = 1'b0;
        checks++; if ({Snoozing, LoadAlm, AlarmMinsOut} !== {1'b1, 1'b1, 6'd39}) begin errors++; $display("FAIL dis_pre: got snz=%0b ld=%0b min=%0d expected 1 1 39", Snoozing, LoadAlm, AlarmMinsOut); end
        AlarmEnableIn = 1'b0;
        #1;
        checks++; if (AlarmEnable !== 1'b0) begin errors++; $display("FAIL enable_follow_lo: got %0b expected 0", AlarmEnable); end
        tick();
        checks++; if ({Snoozing, SnoozeCnt, LoadAlm, AlarmMinsOut} !== {1'b0, 3'd0, 1'b0, 6'd39}) begin errors++; $display("FAIL dis_gap: got snz=%0b cnt=%0d ld=%0b min=%0d expected 0 0 0 39", Snoozing, SnoozeCnt, LoadAlm, AlarmMinsOut); end
        tick();
        checks++; if ({LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {1'b1, 4'd6, 6'd30, 1'b0}) begin errors++; $display("FAIL dis_restore: got ld=%0b %0d:%0d/%0b expected 1 6:30/0", LoadAlm, AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        tick();
        ring_start();
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("FAIL dis_no_ring: got %0b expected 0", Buzzer); end
        AlarmEnableIn = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_ring();
        ring_start();
        SnoozeBtn = 1'b1; tick(); SnoozeBtn = 1'b0;
        ring_start();
        SnoozeBtn = 1'b1; tick(); SnoozeBtn = 1'b0;
        ring_start();
        checks++; if ({Buzzer, SnoozeCnt} !== {1'b1, 3'd2}) begin errors++; $display("FAIL midring_pre: got buz=%0b cnt=%0d expected 1 2", Buzzer, SnoozeCnt); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if ({Buzzer, SnoozeCnt, LoadAlm, Snoozing} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL midring_reset: got buz=%0b cnt=%0d ld=%0b snz=%0b expected 0 0 0 0", Buzzer, SnoozeCnt, LoadAlm, Snoozing); end
        checks++; if ({AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut} !== {4'd12, 6'd0, 1'b0}) begin errors++; $display("FAIL midring_reset_out: got %0d:%0d/%0b expected 12:0/0", AlarmHoursOut, AlarmMinsOut, AlarmAM_PMOut); end
        tick();
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; AlarmMatch = 1'b0; UserLoadAlm = 1'b0;
        UserMins = '0; UserHours = 4'd12; UserAM_PM = 1'b0;
        AlarmEnableIn = 1'b0; SnoozeBtn = 1'b0; StopBtn = 1'b0;
        set_time(4'd12, 6'd0, 6'd0, 1'b0);
        test_reset();
        test_user_load();
        test_trigger_no_retrigger();
        test_snooze_wrap_pm();
        test_snooze_12_58();
        test_auto_snooze();
        test_stop_wins();
        test_disable_in_snooze();
        test_reset_mid_ring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_snooze_ctrl.md
Name: alarm_snooze_ctrl

Overview:
Controller that sequences the alarm clock datapath's alarm registers and turns its raw Alarm match level into a user-facing ring/snooze/stop behaviour. It holds the user's programmed alarm time and issues LoadAlm pulses: the user time on programming or stop, and a computed time on snooze. It drives the buzzer, applies a ring timeout and limits the number of snoozes. It sits between the front-panel buttons and the clock datapath, on the same Clock_1Sec domain.

Parameters:
SNOOZE_MINS, 9, minutes added to current time on snooze; legal 1..59
RING_SECS, 60, seconds of continuous ringing before auto-snooze/stop; legal 2..63
MAX_SNOOZES, 3, snoozes allowed per alarm event; legal 1..7

Ports:
Clock_1Sec  in  1  1 Hz system clock, rising edge
Reset  in  1  asynchronous, active-low
AlarmMatch  in  1  datapath Alarm output, level, high while match holds
Secs_C  in  6  current seconds 0..59
Mins_C  in  6  current minutes 0..59
Hours_C  in  4  current hours 1..12
AM_PM  in  1  current AM/PM
UserLoadAlm  in  1  user programs a new alarm, 1-cycle strobe
UserMins  in  6  user alarm minutes
UserHours  in  4  user alarm hours
UserAM_PM  in  1  user alarm AM/PM
AlarmEnableIn  in  1  user alarm on/off switch, level
SnoozeBtn  in  1  snooze request, synchronised, 1-cycle strobe
StopBtn  in  1  stop request, synchronised, 1-cycle strobe
LoadAlm  out  1  1-cycle load strobe to datapath
AlarmMinsOut  out  6  alarm minutes to datapath
AlarmHoursOut  out  4  alarm hours to datapath
AlarmAM_PMOut  out  1  alarm AM/PM to datapath
AlarmEnable  out  1  enable to datapath, equals AlarmEnableIn
Buzzer  out  1  high while ringing
Snoozing  out  1  high in SNOOZE state
SnoozeCnt  out  3  snoozes used in the current alarm event

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE. Buzzer=0, Snoozing=0, SnoozeCnt=0, LoadAlm=0. Stored user alarm = 12:00 AM_PM=0. AlarmMinsOut=0, AlarmHoursOut=12, AlarmAM_PMOut=0. Ring counter=0, match-edge register=0.
- All outputs are registered except AlarmEnable, which is a direct copy of AlarmEnableIn.
- Trigger: match_rise = AlarmMatch & ~AlarmMatch_q. Only a rising edge triggers, because the datapath holds AlarmMatch high for the whole matching minute.
- States: IDLE, RINGING, SNOOZE.
- Event priority per cycle, highest first: UserLoadAlm > AlarmEnableIn=0 > StopBtn > SnoozeBtn > ring timeout > match_rise.
- UserLoadAlm, any state: store User* values and drive them on Alarm*Out with LoadAlm=1 the next cycle. Go to IDLE, SnoozeCnt=0, Buzzer=0.
- AlarmEnableIn=0 in RINGING or SNOOZE: go to IDLE. Restore the user alarm with one LoadAlm pulse, SnoozeCnt=0.
- IDLE + match_rise + AlarmEnableIn: go to RINGING next edge, Buzzer=1, ring counter=0.
- RINGING: the ring counter increments each cycle.
  - StopBtn: go to IDLE, restore the user alarm (LoadAlm pulse), SnoozeCnt=0.
  - SnoozeBtn with SnoozeCnt<MAX_SNOOZES: compute snooze time, LoadAlm pulse, go to SNOOZE, SnoozeCnt+1.
  - SnoozeBtn with SnoozeCnt==MAX_SNOOZES: ignored, keep ringing.
  - Ring counter reaches RING_SECS-1 with no button: treated exactly as SnoozeBtn if snoozes remain, otherwise as StopBtn.
- SNOOZE: Buzzer=0, Snoozing=1.
  - match_rise: go to RINGING, ring counter=0.
  - StopBtn: go to IDLE, restore the user alarm.
  - SnoozeBtn: ignored.
- Snooze time = current time + SNOOZE_MINS:
  - m = Mins_C + SNOOZE_MINS (7-bit). If m>=60, m-=60 and the hour advances.
  - Hour advance: 11->12 toggles AM/PM; 12->1 does not toggle. This matches the datapath's roll-over.
- LoadAlm is always exactly 1 cycle wide. Alarm*Out are stable from that cycle until the next load.
- At most one LoadAlm per cycle. A transition that needs a load while LoadAlm is high re-asserts it the following cycle; LoadAlm is never held for 2 cycles with changing data.

Decomposition:
- Shared package alarm_pkg:
  - state encoding IDLE/RINGING/SNOOZE
  - constants MINS_PER_HOUR=60, HOURS_MAX=12
  - time field widths 6/6/4
- Sub-module alarm_time_add: combinational 12-hour time + N minutes (N<60) with AM/PM toggle. Reusable by the datapath team.

Test Plan:
- Reset mid-ring (Buzzer=1, SnoozeCnt=2), Reset low -> Buzzer=0, SnoozeCnt=0, Alarm*Out=12:00/0, LoadAlm=0 immediately.
- UserLoadAlm with 6:30 AM (AM_PM=0), then AlarmMatch rises -> LoadAlm pulse with 6/30/0 one cycle after the strobe; Buzzer=1 one cycle after the rise; AlarmMatch held high 60 cycles gives no retrigger.
- Ringing at 11:55:10 PM (AM_PM=1), SnoozeBtn -> LoadAlm with 12:04 AM_PM=0, Snoozing=1, SnoozeCnt=1; AlarmMatch rise later -> Buzzer=1.
- Ringing at 12:58 with SNOOZE_MINS=9, SnoozeBtn -> alarm 1:07, AM/PM unchanged.
- No button for RING_SECS=60 cycles -> auto-snooze at cycle 60. After 3 snoozes the 4th timeout -> IDLE, LoadAlm restores user 6:30/0, SnoozeCnt=0.
- SnoozeBtn and StopBtn in the same cycle while ringing -> stop wins: IDLE, user alarm restored. AlarmEnableIn=0 during SNOOZE -> IDLE with restore; AlarmEnable output follows combinationally.
